// File: rtl/mem_access_stage_if.sv
// Bus bundle between the EX/MEM boundary and the MEM stage, plus the debug read port.
interface mem_access_stage_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 10,
  parameter int unsigned NB_REG  = 5
);
  logic               i_stall;
  logic               i_valid;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] i_store_data;
  logic               i_mem_read;
  logic               i_mem_write;
  logic [1:0]         i_width;
  logic               i_unsigned;
  logic               i_reg_write;
  logic               i_mem_to_reg;
  logic [NB_REG-1:0]  i_rd;
  logic [NB_ADDR-1:0] i_dbg_addr;

  logic               o_valid;
  logic [NB_DATA-1:0] o_wb_data;
  logic [NB_DATA-1:0] o_alu_result;
  logic [NB_REG-1:0]  o_rd;
  logic               o_reg_write;
  logic               o_misaligned;
  logic [NB_DATA-1:0] o_dbg_data;

  modport master (
    output i_stall, i_valid, i_alu_result, i_store_data, i_mem_read, i_mem_write,
    output i_width, i_unsigned, i_reg_write, i_mem_to_reg, i_rd, i_dbg_addr,
    input  o_valid, o_wb_data, o_alu_result, o_rd, o_reg_write, o_misaligned, o_dbg_data
  );

  modport slave (
    input  i_stall, i_valid, i_alu_result, i_store_data, i_mem_read, i_mem_write,
    input  i_width, i_unsigned, i_reg_write, i_mem_to_reg, i_rd, i_dbg_addr,
    output o_valid, o_wb_data, o_alu_result, o_rd, o_reg_write, o_misaligned, o_dbg_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte-lane data memory, load extension and the MEM/WB register.
// The lane logic assumes a 32-bit datapath (four byte lanes).
module mem_access_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 10,
  parameter int unsigned NB_REG  = 5
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_access_stage_if.slave bus
);

  localparam int unsigned Depth = 2 ** NB_ADDR;

  localparam logic [1:0] WidthByte = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;

  logic [NB_DATA-1:0] mem_q [Depth];

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         offset;
  logic               misal_raw;
  logic               misaligned_d;
  logic [3:0]         be;
  logic [NB_DATA-1:0] wdata;
  logic               we;
  logic               re;

  logic [NB_DATA-1:0] rdata_q;
  logic [NB_DATA-1:0] dbg_q;
  logic               valid_q;
  logic [NB_DATA-1:0] alu_q;
  logic [NB_REG-1:0]  rd_q;
  logic               reg_write_q;
  logic               misaligned_q;
  logic               mem_to_reg_q;
  logic [1:0]         offset_q;
  logic [1:0]         width_q;
  logic               unsigned_q;

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_DATA-1:0] load_data;

  // Upper address bits are dropped, so addresses wrap around the memory.
  assign word_idx = bus.i_alu_result[NB_ADDR+1:2];
  assign offset   = bus.i_alu_result[1:0];

  // Decode alignment, byte enables and lane-replicated store data.
  always_comb begin
    misal_raw = 1'b0;
    be        = 4'b1111;
    wdata     = bus.i_store_data;
    case (bus.i_width)
      WidthByte: begin
        be    = 4'b0001 << offset;
        wdata = {4{bus.i_store_data[7:0]}};
      end
      WidthHalf: begin
        misal_raw = offset[0];
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{bus.i_store_data[15:0]}};
      end
      default: begin
        // 2'b10 is handled as a word access.
        misal_raw = (offset != 2'b00);
      end
    endcase
    misaligned_d = bus.i_valid && (bus.i_mem_read || bus.i_mem_write) && misal_raw;
    // Reset is folded in so a store on an edge inside reset is dropped.
    we = i_rst_n && !bus.i_stall && bus.i_valid && bus.i_mem_write && !misal_raw;
    re = !bus.i_stall && bus.i_valid && bus.i_mem_read;
  end

  // Data memory write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Pipeline read port, gated off while stalled so the load data holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[word_idx];
    end
  end

  // Debug read port, free-running and independent of stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= mem_q[bus.i_dbg_addr];
    end
  end

  // MEM/WB boundary register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      mem_to_reg_q <= 1'b0;
      offset_q     <= 2'b00;
      width_q      <= 2'b00;
      unsigned_q   <= 1'b0;
    end else if (!bus.i_stall) begin
      valid_q      <= bus.i_valid;
      alu_q        <= bus.i_alu_result;
      rd_q         <= bus.i_rd;
      reg_write_q  <= bus.i_valid && bus.i_reg_write && !misaligned_d;
      misaligned_q <= misaligned_d;
      mem_to_reg_q <= bus.i_mem_to_reg;
      offset_q     <= offset;
      width_q      <= bus.i_width;
      unsigned_q   <= bus.i_unsigned;
    end
  end

  // Lane select and sign/zero extension from the registered access fields.
  always_comb begin
    byte_sel  = rdata_q[{offset_q, 3'b000} +: 8];
    half_sel  = offset_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = rdata_q;
    case (width_q)
      WidthByte: load_data = {{(NB_DATA-8){byte_sel[7] & ~unsigned_q}}, byte_sel};
      WidthHalf: load_data = {{(NB_DATA-16){half_sel[15] & ~unsigned_q}}, half_sel};
      default:   load_data = rdata_q;
    endcase
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_wb_data    = mem_to_reg_q ? load_data : alu_q;
  assign bus.o_alu_result = alu_q;
  assign bus.o_rd         = rd_q;
  assign bus.o_reg_write  = reg_write_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_dbg_data   = dbg_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: reset, loads/stores, alignment, aliasing, stall.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_access_stage_if #(.NB_DATA(32), .NB_ADDR(10), .NB_REG(5)) bus ();

  mem_access_stage #(.NB_DATA(32), .NB_ADDR(10), .NB_REG(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] w,
                       input logic u, input logic rw, input logic m2r, input logic [4:0] rdi,
                       input logic [31:0] alu, input logic [31:0] sd);
    bus.i_valid      = v;
    bus.i_mem_read   = rd;
    bus.i_mem_write  = wr;
    bus.i_width      = w;
    bus.i_unsigned   = u;
    bus.i_reg_write  = rw;
    bus.i_mem_to_reg = m2r;
    bus.i_rd         = rdi;
    bus.i_alu_result = alu;
    bus.i_store_data = sd;
  endtask

  task automatic drive_idle;
    drive(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic drive_sw(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w);
    drive(1'b1, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 5'd0, addr, data);
  endtask

  task automatic drive_ld(input logic [31:0] addr, input logic [1:0] w, input logic u,
                          input logic [4:0] rdi);
    drive(1'b1, 1'b1, 1'b0, w, u, 1'b1, 1'b1, rdi, addr, 32'h0);
  endtask

  function automatic logic [103:0] all_outs();
    return {bus.o_valid, bus.o_wb_data, bus.o_alu_result, bus.o_rd, bus.o_reg_write,
            bus.o_misaligned, bus.o_dbg_data};
  endfunction

  task automatic test_reset;
    logic [103:0] outs;
    outs = all_outs();
    checks++;
    if (outs !== 104'h0) begin
      errors++;
      $display("FAIL reset_init: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    drive_sw(32'h40, 32'h0, 2'b11);
    step;
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 5'd3, 32'h1234, 32'h0);
    step;
    checks++;
    if (bus.o_wb_data !== 32'h1234) begin
      errors++;
      $display("FAIL pre_reset_wb: got %h expected 00001234", bus.o_wb_data);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = all_outs();
    checks++;
    if (outs !== 104'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", outs);
    end
    drive_sw(32'h40, 32'hAAAA_AAAA, 2'b11);
    step;
    step;
    rst_n = 1'b1;
    drive_ld(32'h40, 2'b11, 1'b0, 5'd4);
    step;
    checks++;
    if (bus.o_wb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_store_suppressed: got %h expected 00000000", bus.o_wb_data);
    end
    checks++;
    if ({bus.o_valid, bus.o_reg_write, bus.o_rd} !== {1'b1, 1'b1, 5'd4}) begin
      errors++;
      $display("FAIL reset_release: got %b expected 1100100",
               {bus.o_valid, bus.o_reg_write, bus.o_rd});
    end
  endtask

  task automatic test_loads;
    logic [31:0] addr [5];
    logic [1:0]  wid  [5];
    logic        uns  [5];
    logic [31:0] exp  [5];
    addr = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h12};
    wid  = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b01};
    uns  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp  = '{32'hDEADBEEF, 32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD};
    drive_sw(32'h10, 32'hDEADBEEF, 2'b11);
    step;
    checks++;
    if ({bus.o_valid, bus.o_reg_write, bus.o_misaligned} !== 3'b100) begin
      errors++;
      $display("FAIL sw_flags: got %b expected 100",
               {bus.o_valid, bus.o_reg_write, bus.o_misaligned});
    end
    for (int i = 0; i < 5; i++) begin
      drive_ld(addr[i], wid[i], uns[i], 5'(i + 2));
      step;
      checks++;
      if (bus.o_wb_data !== exp[i] || bus.o_rd !== 5'(i + 2)) begin
        errors++;
        $display("FAIL load_%0d: got %h rd %0d expected %h rd %0d", i, bus.o_wb_data,
                 bus.o_rd, exp[i], i + 2);
      end
    end
  endtask

  task automatic test_sub_word_store;
    drive_sw(32'h20, 32'h0, 2'b11);
    step;
    drive_sw(32'h21, 32'hFFFF_FF55, 2'b00);
    step;
    drive_sw(32'h22, 32'hABCD_1234, 2'b01);
    step;
    drive_ld(32'h20, 2'b11, 1'b0, 5'd5);
    step;
    checks++;
    if (bus.o_wb_data !== 32'h12345500) begin
      errors++;
      $display("FAIL sub_word_store: got %h expected 12345500", bus.o_wb_data);
    end
  endtask

  task automatic test_misaligned;
    drive_sw(32'h30, 32'h11223344, 2'b11);
    step;
    drive_ld(32'h13, 2'b11, 1'b0, 5'd6);
    step;
    checks++;
    if ({bus.o_valid, bus.o_reg_write, bus.o_misaligned} !== 3'b101) begin
      errors++;
      $display("FAIL misaligned_lw: got %b expected 101",
               {bus.o_valid, bus.o_reg_write, bus.o_misaligned});
    end
    drive_sw(32'h31, 32'h0000FFFF, 2'b01);
    step;
    checks++;
    if ({bus.o_valid, bus.o_reg_write, bus.o_misaligned} !== 3'b101) begin
      errors++;
      $display("FAIL misaligned_sh: got %b expected 101",
               {bus.o_valid, bus.o_reg_write, bus.o_misaligned});
    end
    drive_ld(32'h30, 2'b11, 1'b0, 5'd6);
    step;
    checks++;
    if (bus.o_wb_data !== 32'h11223344) begin
      errors++;
      $display("FAIL misaligned_no_write: got %h expected 11223344", bus.o_wb_data);
    end
    checks++;
    if ({bus.o_reg_write, bus.o_misaligned} !== 2'b10) begin
      errors++;
      $display("FAIL aligned_flags: got %b expected 10", {bus.o_reg_write, bus.o_misaligned});
    end
    // Width 2'b10 behaves as a word: offset 2 is a fault.
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6, 32'h32, 32'h0);
    step;
    checks++;
    if (bus.o_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL width10_misaligned: got %b expected 1", bus.o_misaligned);
    end
  endtask

  task automatic test_pass_through;
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 5'd9, 32'h7FFFFFFF, 32'h0);
    step;
    checks++;
    if ({bus.o_wb_data, bus.o_alu_result} !== {32'h7FFFFFFF, 32'h7FFFFFFF}) begin
      errors++;
      $display("FAIL pass_data: got %h/%h expected 7fffffff/7fffffff", bus.o_wb_data,
               bus.o_alu_result);
    end
    checks++;
    if ({bus.o_rd, bus.o_reg_write, bus.o_valid} !== {5'd9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pass_ctrl: got %b expected 0100111", {bus.o_rd, bus.o_reg_write,
               bus.o_valid});
    end
    drive(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 5'd9, 32'h1, 32'h0);
    step;
    checks++;
    if ({bus.o_valid, bus.o_reg_write} !== 2'b00) begin
      errors++;
      $display("FAIL invalid_bubble: got %b expected 00", {bus.o_valid, bus.o_reg_write});
    end
    // A store marked invalid must not reach memory.
    drive(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h30, 32'hFFFF_FFFF);
    step;
    drive_sw(32'h1010, 32'hCAFEF00D, 2'b11);
    bus.i_dbg_addr = 10'd4;
    step;
    drive_ld(32'h10, 2'b11, 1'b0, 5'd10);
    step;
    checks++;
    if (bus.o_wb_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL alias_load: got %h expected cafef00d", bus.o_wb_data);
    end
    checks++;
    if (bus.o_dbg_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL alias_dbg: got %h expected cafef00d", bus.o_dbg_data);
    end
    drive_ld(32'h30, 2'b11, 1'b0, 5'd10);
    step;
    checks++;
    if (bus.o_wb_data !== 32'h11223344) begin
      errors++;
      $display("FAIL invalid_store: got %h expected 11223344", bus.o_wb_data);
    end
  endtask

  task automatic test_stall;
    drive_sw(32'h50, 32'h0, 2'b11);
    step;
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 5'd7, 32'h55, 32'h0);
    step;
    checks++;
    if (bus.o_wb_data !== 32'h55) begin
      errors++;
      $display("FAIL stall_pre: got %h expected 00000055", bus.o_wb_data);
    end
    bus.i_dbg_addr = 10'd20;
    drive_sw(32'h50, 32'h0BADF00D, 2'b11);
    bus.i_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++;
      if ({bus.o_valid, bus.o_wb_data, bus.o_rd, bus.o_reg_write} !==
          {1'b1, 32'h55, 5'd7, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %b %h %0d %b expected 1 00000055 7 1", c,
                 bus.o_valid, bus.o_wb_data, bus.o_rd, bus.o_reg_write);
      end
      checks++;
      if (bus.o_dbg_data !== 32'h0) begin
        errors++;
        $display("FAIL stall_no_write_%0d: got %h expected 00000000", c, bus.o_dbg_data);
      end
    end
    bus.i_stall = 1'b0;
    step;
    checks++;
    if ({bus.o_valid, bus.o_reg_write, bus.o_dbg_data} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL stall_release: got %b %b %h expected 1 0 00000000", bus.o_valid,
               bus.o_reg_write, bus.o_dbg_data);
    end
    drive_ld(32'h50, 2'b11, 1'b0, 5'd8);
    step;
    checks++;
    if (bus.o_dbg_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL stall_dbg_new: got %h expected 0badf00d", bus.o_dbg_data);
    end
    checks++;
    if (bus.o_wb_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL stall_load_new: got %h expected 0badf00d", bus.o_wb_data);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.i_stall    = 1'b0;
    bus.i_dbg_addr = '0;
    drive_idle();
    #3 rst_n = 1'b0;
    step;
    step;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_misaligned();
    test_pass_through();
    test_stall();
    drive_idle();
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
